// File: rtl/threshold_image_writer_if.sv
// Pixel-stream, memory-write and frame-control signals of the threshold image writer.
// The writer itself takes the slave side; the host or bench drives the master side.
interface threshold_image_writer_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic                  start;
  logic                  pixel_in_valid;
  logic                  pixel_in;
  logic                  pixel_in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [7:0]            mem_wr_data;
  logic                  mem_wr_ready;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output start, pixel_in_valid, pixel_in, mem_wr_ready,
    input  pixel_in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, frame_done
  );

  modport slave (
    input  start, pixel_in_valid, pixel_in, mem_wr_ready,
    output pixel_in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, frame_done
  );
endinterface

// File: rtl/threshold_image_writer.sv
// Packs a 1-bit-per-pixel stream MSB-first into bytes and writes one frame in raster order,
// each row byte-aligned with zero padding in its last byte.
module threshold_image_writer #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 16
) (
  input logic                      clk,
  input logic                      reset,
  threshold_image_writer_if.slave  bus
);

  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [COL_W-1:0]      col_r;
  logic [ROW_W-1:0]      row_r;
  logic [2:0]            bitidx_r;
  logic [7:0]            shift_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            wr_data_r;
  logic                  last_byte_r;
  logic                  ready_r;
  logic                  wr_en_r;
  logic                  busy_r;
  logic                  done_r;

  logic [7:0]            byte_s;
  logic                  last_col_s;
  logic                  close_s;

  // Byte under construction with the current pixel merged in, and byte-closing conditions
  always_comb begin
    byte_s                   = shift_r;
    byte_s[3'd7 - bitidx_r]  = bus.pixel_in;
    last_col_s               = (col_r == LAST_COL);
    close_s                  = (bitidx_r == 3'd7) || last_col_s;
  end

  // Frame sequencer: counters, packing, write handshake and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      col_r       <= '0;
      row_r       <= '0;
      bitidx_r    <= 3'd0;
      shift_r     <= 8'd0;
      addr_r      <= '0;
      wr_data_r   <= 8'd0;
      last_byte_r <= 1'b0;
      ready_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r  <= RUN;
            col_r    <= '0;
            row_r    <= '0;
            bitidx_r <= 3'd0;
            shift_r  <= 8'd0;
            addr_r   <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          if (bus.pixel_in_valid) begin
            if (last_col_s) begin
              col_r <= '0;
              row_r <= (row_r == LAST_ROW) ? '0 : row_r + ROW_W'(1);
            end else begin
              col_r <= col_r + COL_W'(1);
            end
            // A row end closes the byte early; the unfilled LSBs stay zero from shift_r
            if (close_s) begin
              wr_data_r   <= byte_s;
              last_byte_r <= last_col_s && (row_r == LAST_ROW);
              state_r     <= WRITE;
              wr_en_r     <= 1'b1;
              ready_r     <= 1'b0;
            end else begin
              shift_r  <= byte_s;
              bitidx_r <= bitidx_r + 3'd1;
            end
          end else begin
            state_r <= RUN;
          end
        end
        WRITE: begin
          if (bus.mem_wr_ready) begin
            addr_r   <= addr_r + ADDR_WIDTH'(1);
            bitidx_r <= 3'd0;
            shift_r  <= 8'd0;
            wr_en_r  <= 1'b0;
            if (last_byte_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              ready_r <= 1'b1;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel_in_ready = ready_r;
  assign bus.mem_wr_en      = wr_en_r;
  assign bus.mem_wr_addr    = addr_r;
  assign bus.mem_wr_data    = wr_data_r;
  assign bus.busy           = busy_r;
  assign bus.frame_done     = done_r;

endmodule
